// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use / branch / fetch
// bubbles, data-memory wait with timeout, and a saturating stall counter.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   RUN   | pipeline flowing; per-cycle hazards resolved by priority
//   DWAIT | data access outstanding; whole pipeline held, E masked
//   ERR   | data access timed out; pipeline frozen until reset
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  rdE,
  input  logic [4:0]  rdM,
  input  logic [4:0]  rdW,
  input  logic        we_regE,
  input  logic        we_regM,
  input  logic        we_regW,
  input  logic        ld_E,
  input  logic        brch_takenE,
  input  logic        imem_ack,
  input  logic        dmem_req_M,
  input  logic        dmem_ack,
  output logic [1:0]  fwd_aE,
  output logic [1:0]  fwd_bE,
  output logic        enbF,
  output logic        enbD,
  output logic        enbE,
  output logic        enbM,
  output logic        flashD,
  output logic        flashE,
  output logic        flashM,
  output logic        nop_gen,
  output logic        err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    ERR   = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       load_use;
  logic       any_enb;

  // Operand source for one execute-stage register: M result wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Forwarding muxes; forced to register-file source while in reset.
  always_comb begin
    fwd_aE = 2'b00;
    fwd_bE = 2'b00;
    if (!rst) begin
      fwd_aE = fwd_sel(rs1E, we_regM, rdM, we_regW, rdW);
      fwd_bE = fwd_sel(rs2E, we_regM, rdM, we_regW, rdW);
    end
  end

  assign load_use = ld_E && we_regE && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  // Reserved clear for the M register.
  assign flashM = 1'b0;

  // State register and data-wait timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state and hold/clear decode; all outputs idle while in reset.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    enbF      = 1'b0;
    enbD      = 1'b0;
    enbE      = 1'b0;
    enbM      = 1'b0;
    flashD    = 1'b0;
    flashE    = 1'b0;
    nop_gen   = 1'b0;
    err       = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (dmem_req_M && !dmem_ack) begin
            state_nxt = DWAIT;
            wcnt_nxt  = 8'd0;
            enbF      = 1'b1;
            enbD      = 1'b1;
            enbE      = 1'b1;
            enbM      = 1'b1;
            nop_gen   = 1'b1;
          end else if (brch_takenE) begin
            flashD = 1'b1;
            flashE = 1'b1;
          end else if (load_use) begin
            // Fetch wait is subsumed: F/D already hold, so no D bubble.
            enbF   = 1'b1;
            enbD   = 1'b1;
            flashE = 1'b1;
          end else if (!imem_ack) begin
            enbF   = 1'b1;
            flashD = 1'b1;
          end
        end
        DWAIT: begin
          if (dmem_ack) begin
            // Holds drop in the ack cycle so the pipeline advances now.
            state_nxt = RUN;
          end else begin
            enbF    = 1'b1;
            enbD    = 1'b1;
            enbE    = 1'b1;
            enbM    = 1'b1;
            nop_gen = 1'b1;
            if (wcnt == 8'hFF)
              state_nxt = ERR;
            else
              wcnt_nxt = wcnt + 8'd1;
          end
        end
        ERR: begin
          enbF    = 1'b1;
          enbD    = 1'b1;
          enbE    = 1'b1;
          enbM    = 1'b1;
          nop_gen = 1'b1;
          err     = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign any_enb = enbF || enbD || enbE || enbM;

  // Saturating count of cycles in which any pipeline register holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if (any_enb && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
